gray_colorize: RTL and testbench

- Streaming pixel re-colouriser: the output-side complement of the grayscale filter.
- Takes 4-bit gray intensities and expands them back into 12-bit RGB444 for the VGA/display path.
- Colour map is selectable: replicate, heat map, inverted or threshold.
- Sits between the gray pixel store/filter chain and the display pixel FIFO, with valid/ready handshake on both sides.

---
 rtl/gray_colorize_pkg.sv | 35 +++
 rtl/gray_colorize_colormap_lut.sv | 73 +++++++
 rtl/gray_colorize.sv | 172 +++++++++++++++++
 tb/tb_gray_colorize.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_colorize_pkg.sv
// -----------------------------------------------------------------------------
// gray_colorize_pkg
// Shared types and constants for the gray-to-RGB444 re-colouriser.
//   cmap_t      : colour map selector (replicate, heat, inverted, threshold)
//   rgb444_t    : packed {R[3:0], G[3:0], B[3:0]} pixel
//   HEAT_G_OFS  : gray level at which the green heat ramp starts
//   HEAT_B_OFS  : gray level at which the blue heat ramp starts
//   sat_nib()   : clamps an unsigned intermediate to the 4-bit range 0..15
// -----------------------------------------------------------------------------
package gray_colorize_pkg;

    typedef enum logic [1:0] {
        CMAP_GRAY = 2'd0,
        CMAP_HEAT = 2'd1,
        CMAP_INV  = 2'd2,
        CMAP_THR  = 2'd3
    } cmap_t;

    typedef logic [11:0] rgb444_t;

    localparam logic [3:0] HEAT_G_OFS = 4'd5;
    localparam logic [3:0] HEAT_B_OFS = 4'd10;

    // Saturate a wide unsigned value to a colour nibble; never wraps.
    function automatic logic [3:0] sat_nib(input logic [9:0] v);
        logic [3:0] r;
        if (v > 10'd15) begin
            r = 4'd15;
        end else begin
            r = v[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_colorize_colormap_lut.sv
// -----------------------------------------------------------------------------
// colormap_lut
// Purely combinational colour map from a 4-bit gray level to RGB444.
//   gray : gray intensity 0..15
//   mode : colour map select (cmap_t)
//   thr  : threshold level used by CMAP_THR
//   rgb  : resulting {R,G,B} pixel
// Heat-map ramps use a 10-bit intermediate and saturate to 15, so the result
// never wraps for any HEAT_GAIN below 64.
// -----------------------------------------------------------------------------
module colormap_lut
    import gray_colorize_pkg::*;
#(
    parameter int HEAT_GAIN = 3
) (
    input  logic [3:0] gray,
    input  cmap_t      mode,
    input  logic [3:0] thr,
    output rgb444_t    rgb
);

    localparam logic [9:0] GAIN_W = 10'(HEAT_GAIN);

    logic [9:0] g_w_s;
    logic [9:0] r_prod_s;
    logic [9:0] g_prod_s;
    logic [9:0] b_prod_s;
    logic [3:0] heat_r_s;
    logic [3:0] heat_g_s;
    logic [3:0] heat_b_s;
    logic [3:0] inv_s;

    assign g_w_s = {6'd0, gray};

    // Heat-map ramps; the offset subtraction is only used when gray is past
    // the offset, so its wrap-around value for small gray levels is discarded.
    always_comb begin
        r_prod_s = GAIN_W * g_w_s;
        g_prod_s = GAIN_W * (g_w_s - {6'd0, HEAT_G_OFS});
        b_prod_s = GAIN_W * (g_w_s - {6'd0, HEAT_B_OFS});
        heat_r_s = sat_nib(r_prod_s);
        if (gray < HEAT_G_OFS) begin
            heat_g_s = 4'd0;
        end else begin
            heat_g_s = sat_nib(g_prod_s);
        end
        if (gray < HEAT_B_OFS) begin
            heat_b_s = 4'd0;
        end else begin
            heat_b_s = sat_nib(b_prod_s);
        end
        inv_s = 4'd15 - gray;
    end

    // Final colour selection by map.
    always_comb begin
        rgb = 12'h000;
        case (mode)
            CMAP_GRAY: rgb = {gray, gray, gray};
            CMAP_HEAT: rgb = {heat_r_s, heat_g_s, heat_b_s};
            CMAP_INV:  rgb = {inv_s, inv_s, inv_s};
            CMAP_THR: begin
                if (gray >= thr) begin
                    rgb = 12'hFFF;
                end else begin
                    rgb = 12'h000;
                end
            end
            default:   rgb = 12'h000;
        endcase
    end

endmodule

// File: rtl/gray_colorize.sv
// -----------------------------------------------------------------------------
// gray_colorize
// Streaming re-colouriser: 4-bit gray pixels in, 12-bit RGB444 pixels out,
// two register stages with valid/ready on both sides.
//   clk, rst        : clock, asynchronous active-high reset
//   mode, thr       : colour map and threshold, captured with a start-of-frame
//                     pixel and applied to that pixel and the rest of the frame
//   s_valid/s_ready : input handshake; s_gray, s_sof, s_eol travel with it
//   m_valid/m_ready : output handshake; m_rgb, m_eol travel with it
// S1 holds the gray level, eol and the mode/thr that apply to that pixel.
// The colour map sits between S1 and S2; S2 drives the outputs directly.
// s_ready is combinational from m_ready so a full pipe can shift while the
// downstream accepts, keeping one pixel per clock with no bubbles.
// -----------------------------------------------------------------------------
module gray_colorize
    import gray_colorize_pkg::*;
#(
    parameter int HEAT_GAIN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [3:0]  thr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_gray,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [11:0] m_rgb,
    output logic        m_eol
);

    // Frame-level mode registers
    cmap_t      mode_q, mode_d;
    logic [3:0] thr_q,  thr_d;

    // Stage 1
    logic       v1_q,    v1_d;
    logic [3:0] g1_q,    g1_d;
    logic       eol1_q,  eol1_d;
    cmap_t      mode1_q, mode1_d;
    logic [3:0] thr1_q,  thr1_d;

    // Stage 2
    logic       v2_q,    v2_d;
    rgb444_t    rgb2_q,  rgb2_d;
    logic       eol2_q,  eol2_d;

    logic       adv1_s;
    logic       adv2_s;
    logic       acc_s;
    cmap_t      mode_eff_s;
    logic [3:0] thr_eff_s;
    rgb444_t    lut_rgb_s;

    // Colour map between S1 and S2.
    colormap_lut #(
        .HEAT_GAIN (HEAT_GAIN)
    ) u_lut (
        .gray (g1_q),
        .mode (mode1_q),
        .thr  (thr1_q),
        .rgb  (lut_rgb_s)
    );

    // Stage advance conditions and input acceptance.
    always_comb begin
        adv2_s = ~v2_q | m_ready;
        adv1_s = ~v1_q | adv2_s;
        acc_s  = s_valid & adv1_s;
    end

    // A start-of-frame pixel uses the mode/thr presented with it; every other
    // pixel uses the values latched at the last start of frame.
    always_comb begin
        mode_d     = mode_q;
        thr_d      = thr_q;
        mode_eff_s = mode_q;
        thr_eff_s  = thr_q;
        if (acc_s && s_sof) begin
            mode_d     = cmap_t'(mode);
            thr_d      = thr;
            mode_eff_s = cmap_t'(mode);
            thr_eff_s  = thr;
        end else begin
            mode_d     = mode_q;
            thr_d      = thr_q;
            mode_eff_s = mode_q;
            thr_eff_s  = thr_q;
        end
    end

    // Stage 1 next state: load on accept, empty when it moves on without refill.
    always_comb begin
        v1_d    = v1_q;
        g1_d    = g1_q;
        eol1_d  = eol1_q;
        mode1_d = mode1_q;
        thr1_d  = thr1_q;
        if (adv1_s) begin
            v1_d = acc_s;
        end else begin
            v1_d = v1_q;
        end
        if (acc_s) begin
            g1_d    = s_gray;
            eol1_d  = s_eol;
            mode1_d = mode_eff_s;
            thr1_d  = thr_eff_s;
        end else begin
            g1_d    = g1_q;
            eol1_d  = eol1_q;
            mode1_d = mode1_q;
            thr1_d  = thr1_q;
        end
    end

    // Stage 2 next state: data only changes when a valid S1 pixel moves in, so
    // outputs hold their value both during stalls and after the pipe drains.
    always_comb begin
        v2_d   = v2_q;
        rgb2_d = rgb2_q;
        eol2_d = eol2_q;
        if (adv2_s) begin
            v2_d = v1_q;
        end else begin
            v2_d = v2_q;
        end
        if (adv2_s && v1_q) begin
            rgb2_d = lut_rgb_s;
            eol2_d = eol1_q;
        end else begin
            rgb2_d = rgb2_q;
            eol2_d = eol2_q;
        end
    end

    // State registers for mode latch and both pipeline stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= CMAP_GRAY;
            thr_q   <= 4'd0;
            v1_q    <= 1'b0;
            g1_q    <= 4'd0;
            eol1_q  <= 1'b0;
            mode1_q <= CMAP_GRAY;
            thr1_q  <= 4'd0;
            v2_q    <= 1'b0;
            rgb2_q  <= 12'h000;
            eol2_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            thr_q   <= thr_d;
            v1_q    <= v1_d;
            g1_q    <= g1_d;
            eol1_q  <= eol1_d;
            mode1_q <= mode1_d;
            thr1_q  <= thr1_d;
            v2_q    <= v2_d;
            rgb2_q  <= rgb2_d;
            eol2_q  <= eol2_d;
        end
    end

    assign s_ready = adv1_s;
    assign m_valid = v2_q;
    assign m_rgb   = rgb2_q;
    assign m_eol   = eol2_q;

endmodule

// File: tb/tb_gray_colorize.sv
// -----------------------------------------------------------------------------
// tb_gray_colorize
// Directed and randomised-stall stimulus for gray_colorize with a queue-based
// scoreboard: expected {eol, rgb} is pushed on every input accept and popped
// on every output transfer.
// -----------------------------------------------------------------------------
module tb_gray_colorize;

    localparam int HG = 3;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  thr;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_gray;
    logic        s_sof;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_rgb;
    logic        m_eol;

    gray_colorize #(.HEAT_GAIN(HG)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .thr     (thr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_gray  (s_gray),
        .s_sof   (s_sof),
        .s_eol   (s_eol),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rgb   (m_rgb),
        .m_eol   (m_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [12:0] sb_q[$];
    int          tb_mode;
    int          tb_thr;
    logic        last_acc;
    logic        stall_prev;
    logic [13:0] stall_val;
    logic [3:0]  burst_pix[64];

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Independent reference of the colour maps.
    function automatic logic [11:0] model(input int g, input int md, input int th);
        int r, gg, b;
        r = 0; gg = 0; b = 0;
        case (md)
            0: begin r = g; gg = g; b = g; end
            1: begin
                r  = min15(HG * g);
                gg = (g < 5)  ? 0 : min15(HG * (g - 5));
                b  = (g < 10) ? 0 : min15(HG * (g - 10));
            end
            2: begin r = 15 - g; gg = 15 - g; b = 15 - g; end
            default: begin
                r  = (g >= th) ? 15 : 0;
                gg = r;
                b  = r;
            end
        endcase
        return {r[3:0], gg[3:0], b[3:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: evaluate handshakes just after the falling edge where inputs
    // were set, score any output transfer, record any input accept, advance.
    task automatic cycle();
        logic [12:0] exp_v;
        #1;
        if (stall_prev) begin
            check("stall_hold", {2'b00, m_valid, m_eol, m_rgb}, {2'b00, stall_val});
        end
        if (m_ready) begin
            check("rdy_thru", {15'd0, s_ready}, 16'd1);
        end
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 16'd1, 16'd0);
            end else begin
                exp_v = sb_q.pop_front();
                check("pixel", {3'b000, m_eol, m_rgb}, {3'b000, exp_v});
            end
        end
        last_acc = s_valid && s_ready;
        if (last_acc) begin
            if (s_sof) begin
                tb_mode = int'(mode);
                tb_thr  = int'(thr);
            end
            sb_q.push_back({s_eol, model(int'(s_gray), tb_mode, tb_thr)});
        end
        if (m_valid && !m_ready) begin
            stall_prev = 1'b1;
            stall_val  = {m_valid, m_eol, m_rgb};
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic px(input logic sof, input logic eol, input int g);
        s_valid = 1'b1;
        s_sof   = sof;
        s_eol   = eol;
        s_gray  = 4'(g);
        cycle();
    endtask

    task automatic drain();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            cycle();
        end
        check("drain_empty", 16'(sb_q.size()), 16'd0);
        cycle();
        check("drain_idle", {15'd0, m_valid}, 16'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        tb_mode = 0; tb_thr = 0;
        stall_prev = 1'b0; last_acc = 1'b0; stall_val = 14'd0;
        rst = 1'b1; mode = 2'd0; thr = 4'd0;
        s_valid = 1'b0; s_gray = 4'd0; s_sof = 1'b0; s_eol = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mvalid", {15'd0, m_valid}, 16'd0);
        check("rst_rgb",    {4'd0, m_rgb},    16'h0000);
        check("rst_eol",    {15'd0, m_eol},   16'd0);
        check("rst_sready", {15'd0, s_ready}, 16'd1);
        @(negedge clk);

        // Replicate map and two-cycle latency.
        mode = 2'd0; thr = 4'd0;
        px(1'b1, 1'b0, 0);
        check("lat_1clk", {15'd0, m_valid}, 16'd0);
        px(1'b0, 1'b0, 7);
        check("lat_2clk", {15'd0, m_valid}, 16'd1);
        check("first_rgb", {4'd0, m_rgb}, 16'h0000);
        px(1'b0, 1'b1, 15);
        drain();

        // Heat map with saturation.
        mode = 2'd1;
        px(1'b1, 1'b0, 3);
        px(1'b0, 1'b0, 8);
        px(1'b0, 1'b0, 12);
        px(1'b0, 1'b1, 15);
        drain();

        // Threshold, mode change ignored without sof, then sof right after eol.
        mode = 2'd3; thr = 4'd8;
        px(1'b1, 1'b0, 7);
        px(1'b0, 1'b0, 8);
        mode = 2'd2; thr = 4'd0;
        px(1'b0, 1'b1, 4);
        px(1'b1, 1'b0, 4);
        px(1'b1, 1'b1, 0);
        mode = 2'd3; thr = 4'd0;
        px(1'b1, 1'b0, 0);
        px(1'b0, 1'b1, 5);
        drain();

        // 64-pixel burst, eol every 16 pixels, random downstream stalls.
        for (int i = 0; i < 64; i++) begin
            burst_pix[i] = 4'($urandom_range(0, 15));
        end
        mode = 2'd1; thr = 4'd0;
        begin
            int idx;
            int budget;
            idx = 0;
            budget = 0;
            while (idx < 64 && budget < 2000) begin
                m_ready = ($urandom_range(0, 3) != 0);
                s_valid = 1'b1;
                s_sof   = (idx == 0);
                s_eol   = ((idx % 16) == 15);
                s_gray  = burst_pix[idx];
                mode    = 2'($urandom_range(0, 3));
                if (idx == 0) begin
                    mode = 2'd1;
                end
                cycle();
                if (last_acc) begin
                    idx++;
                end
                budget++;
            end
            check("burst_done", 16'(idx), 16'd64);
        end
        drain();

        // Asynchronous reset with a full, stalled pipe.
        mode = 2'd1; thr = 4'd0;
        m_ready = 1'b0;
        px(1'b1, 1'b0, 9);
        px(1'b0, 1'b0, 10);
        check("full_sready", {15'd0, s_ready}, 16'd0);
        check("full_mvalid", {15'd0, m_valid}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mvalid", {15'd0, m_valid}, 16'd0);
        check("arst_rgb",    {4'd0, m_rgb},    16'h0000);
        sb_q.delete();
        tb_mode = 0; tb_thr = 0;
        stall_prev = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        mode = 2'd1;
        px(1'b0, 1'b0, 5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
